sprite_compositor: RTL

Parametrised, pipelined multi-sprite overlay stage between the VGA timing generator and `drawcon`. It replaces the single hard-wired, combinational sprite hit/address logic with N independent sprite channels. Each channel adds per-frame position shadowing, animation frame sequencing and transparent-colour keying. Priority-resolved RGB is produced over a background pixel with a fixed 2-cycle latency, and synchronous sprite ROMs are addressed externally.

---
 rtl/sprite_compositor.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
//
// Multi-sprite overlay stage between the VGA timing generator and drawcon.
// NUM_SPRITES independent channels each own:
//   - position/enable shadow registers, loaded on the per-frame tick so a
//     mid-frame change to pos_x/pos_y/sprite_en never tears the picture;
//   - an animation sequencer (div_cnt prescaler feeding a frame counter);
//   - hit detection and ROM address generation against its shadow position.
// The ROMs are external and synchronous. Channel 0 has the highest priority;
// a transparent (colour-keyed) pixel falls through to the next channel and
// finally to the background pixel i_rgb.
//
// Pipeline (one pixel per clock, no stalls):
//   cycle n   : stage 0 - hit test, rom_addr (combinational), i_rgb captured
//   cycle n+1 : stage 1 - rom_data valid, priority / transparency resolve
//   cycle n+2 : o_rgb / o_hit / o_sprite_id registered outputs
//
// Ports:
//   clk, rst_n        pixel clock; asynchronous active-low reset
//   tick              one-cycle pulse per video frame
//   draw_x, draw_y    current pixel coordinates
//   i_rgb             background pixel aligned with draw_x/draw_y
//   pos_x, pos_y      flattened sprite top-left corners, channel k in slice k
//   sprite_en         per-channel visibility
//   anim_en           per-channel animation enable (0 clears the sequencer)
//   rom_addr          per-channel ROM address {frame, local_y, local_x}
//   rom_data          per-channel ROM data, one cycle after rom_addr
//   o_rgb             composited pixel
//   o_hit             an opaque sprite pixel was selected
//   o_sprite_id       winning channel, 0 when o_hit is 0
// -----------------------------------------------------------------------------
module sprite_compositor #(
    parameter int                    NUM_SPRITES = 4,
    parameter int                    SPRITE_W    = 32,
    parameter int                    SPRITE_H    = 64,
    parameter int                    NUM_FRAMES  = 4,
    parameter int                    ANIM_DIV    = 8,
    parameter int                    DATA_WIDTH  = 12,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 12'hF0F,
    parameter int                    X_WIDTH     = 11,
    parameter int                    Y_WIDTH     = 10,
    localparam int                   LX          = $clog2(SPRITE_W),
    localparam int                   LY          = $clog2(SPRITE_H),
    localparam int                   FB          = $clog2(NUM_FRAMES),
    localparam int                   AW          = FB + LY + LX,
    localparam int                   IDW         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tick,
    input  logic [X_WIDTH-1:0]                draw_x,
    input  logic [Y_WIDTH-1:0]                draw_y,
    input  logic [DATA_WIDTH-1:0]             i_rgb,
    input  logic [NUM_SPRITES*X_WIDTH-1:0]    pos_x,
    input  logic [NUM_SPRITES*Y_WIDTH-1:0]    pos_y,
    input  logic [NUM_SPRITES-1:0]            sprite_en,
    input  logic [NUM_SPRITES-1:0]            anim_en,
    output logic [NUM_SPRITES*AW-1:0]         rom_addr,
    input  logic [NUM_SPRITES*DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0]             o_rgb,
    output logic                              o_hit,
    output logic [IDW-1:0]                    o_sprite_id
);

    // Frame counter is at least one bit wide even for single-frame ROMs; in
    // that case it never leaves 0 and its bit is dropped from rom_addr.
    localparam int FW  = (FB > 0) ? FB : 1;
    localparam int DCW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // Extents are compared one bit wider than the coordinates so that a sprite
    // placed near the top of the coordinate range does not wrap around and hit
    // column/row 0.
    localparam logic [X_WIDTH:0] SPAN_X = (X_WIDTH + 1)'(SPRITE_W);
    localparam logic [Y_WIDTH:0] SPAN_Y = (Y_WIDTH + 1)'(SPRITE_H);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // The packed [channel][coordinate] layout matches the flattened port
    // layout, so whole-vector loads from pos_x/pos_y keep channel k in slot k.
    logic [NUM_SPRITES-1:0][X_WIDTH-1:0] shadow_x_q, shadow_x_d;
    logic [NUM_SPRITES-1:0][Y_WIDTH-1:0] shadow_y_q, shadow_y_d;
    logic [NUM_SPRITES-1:0]              shadow_en_q, shadow_en_d;

    logic [NUM_SPRITES-1:0][DCW-1:0]     div_cnt_q, div_cnt_d;
    logic [NUM_SPRITES-1:0][FW-1:0]      frame_q, frame_d;

    // Stage 1 registers: hit vector and background pixel of the pixel whose
    // ROM data is arriving this cycle.
    logic [NUM_SPRITES-1:0]              hit_q, hit_d;
    logic [DATA_WIDTH-1:0]               bg_q, bg_d;

    logic [DATA_WIDTH-1:0]               o_rgb_q, o_rgb_d;
    logic                                o_hit_q, o_hit_d;
    logic [IDW-1:0]                      o_sprite_id_q, o_sprite_id_d;

    // Stage 0 helpers
    logic                                in_x, in_y;
    logic [NUM_SPRITES-1:0][LX-1:0]      loc_x;
    logic [NUM_SPRITES-1:0][LY-1:0]      loc_y;

    // -------------------------------------------------------------------------
    // Shadow registers: only the tick loads new positions/enables.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        shadow_x_d  = shadow_x_q;
        shadow_y_d  = shadow_y_q;
        shadow_en_d = shadow_en_q;
        if (tick) begin
            shadow_x_d  = pos_x;
            shadow_y_d  = pos_y;
            shadow_en_d = sprite_en;
        end
    end

    // -------------------------------------------------------------------------
    // Animation sequencer. A low anim_en clears both counters every cycle,
    // which also makes the clear win over a simultaneous tick.
    // -------------------------------------------------------------------------
    always_comb begin
        div_cnt_d = div_cnt_q;
        frame_d   = frame_q;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            if (!anim_en[k]) begin
                div_cnt_d[k] = '0;
                frame_d[k]   = '0;
            end else if (tick) begin
                if (div_cnt_q[k] == DCW'(ANIM_DIV - 1)) begin
                    div_cnt_d[k] = '0;
                    if (frame_q[k] == FW'(NUM_FRAMES - 1)) begin
                        frame_d[k] = '0;
                    end else begin
                        frame_d[k] = frame_q[k] + 1'b1;
                    end
                end else begin
                    div_cnt_d[k] = div_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 0: hit test and ROM addressing against the shadow copies.
    // -------------------------------------------------------------------------
    always_comb begin
        hit_d    = '0;
        rom_addr = '0;
        loc_x    = '0;
        loc_y    = '0;
        in_x     = 1'b0;
        in_y     = 1'b0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            in_x = ({1'b0, draw_x} >= {1'b0, shadow_x_q[k]}) &&
                   ({1'b0, draw_x} <  ({1'b0, shadow_x_q[k]} + SPAN_X));
            in_y = ({1'b0, draw_y} >= {1'b0, shadow_y_q[k]}) &&
                   ({1'b0, draw_y} <  ({1'b0, shadow_y_q[k]} + SPAN_Y));
            // The low bits of a difference depend only on the low bits of the
            // operands, so the local offset needs no full-width subtraction.
            loc_x[k] = draw_x[LX-1:0] - shadow_x_q[k][LX-1:0];
            loc_y[k] = draw_y[LY-1:0] - shadow_y_q[k][LY-1:0];
            hit_d[k] = shadow_en_q[k] && in_x && in_y;
            if (hit_d[k]) begin
                // With a single frame the concatenation carries one spare
                // frame bit at the top, which the cast discards.
                rom_addr[k*AW +: AW] = AW'({frame_q[k], loc_y[k], loc_x[k]});
            end
        end
        bg_d = i_rgb;
    end

    // -------------------------------------------------------------------------
    // Stage 1: transparency keying and priority resolve.
    // Scanning from the lowest-priority channel up lets the last opaque match,
    // i.e. the lowest index, overwrite the others.
    // -------------------------------------------------------------------------
    always_comb begin
        o_rgb_d       = bg_q;
        o_hit_d       = 1'b0;
        o_sprite_id_d = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (hit_q[k] && (rom_data[k*DATA_WIDTH +: DATA_WIDTH] != TRANSPARENT)) begin
                o_rgb_d       = rom_data[k*DATA_WIDTH +: DATA_WIDTH];
                o_hit_d       = 1'b1;
                o_sprite_id_d = IDW'(k);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of the
    // order the statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_x_q    <= '0;
            shadow_y_q    <= '0;
            shadow_en_q   <= '0;
            div_cnt_q     <= '0;
            frame_q       <= '0;
            hit_q         <= '0;
            bg_q          <= '0;
            o_rgb_q       <= '0;
            o_hit_q       <= 1'b0;
            o_sprite_id_q <= '0;
        end else begin
            shadow_x_q    <= shadow_x_d;
            shadow_y_q    <= shadow_y_d;
            shadow_en_q   <= shadow_en_d;
            div_cnt_q     <= div_cnt_d;
            frame_q       <= frame_d;
            hit_q         <= hit_d;
            bg_q          <= bg_d;
            o_rgb_q       <= o_rgb_d;
            o_hit_q       <= o_hit_d;
            o_sprite_id_q <= o_sprite_id_d;
        end
    end

    assign o_rgb       = o_rgb_q;
    assign o_hit       = o_hit_q;
    assign o_sprite_id = o_sprite_id_q;

endmodule
